alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Multi-cycle ALU execute unit that consumes the 4-bit ALU control code produced by the ALU control decoder.
- Operand pairs are accepted with a valid/ready handshake. AND/OR/ADD/SUB complete in one cycle; SRL is performed iteratively, one bit per clock.
- Returns a registered Result, a Zero flag for branch evaluation, and an Illegal flag for unsupported control codes.

Parameters:
WIDTH, 32, operand/result width in bits
SHAMT_W, 5, shift-amount width; log2(WIDTH); shift amount = In_B[SHAMT_W-1:0]

Ports:
Clock  input  1  single system clock, rising-edge
Reset_n  input  1  asynchronous, active-low reset
In_Valid  input  1  operation request valid
In_Ready  output  1  unit can accept a request
Control  input  4  ALU control code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1110 SRL; all others illegal
In_A  input  WIDTH  operand A (shift source for SRL)
In_B  input  WIDTH  operand B (shift amount for SRL)
Out_Valid  output  1  Result/Zero/Illegal valid
Out_Ready  input  1  consumer accepts result
Result  output  WIDTH  operation result
Zero  output  1  1 when Result == 0
Illegal  output  1  1 when accepted Control was not a supported code

Behaviour:
- Reset (Reset_n low, async): state IDLE, In_Ready=0 while in reset, Out_Valid=0, Result=0, Zero=0, Illegal=0, shift counter=0. Any in-flight operation is aborted with no result. In_Ready=1 from the first cycle after release.
- States: IDLE, SHIFT, DONE. In_Ready = (state==IDLE). Out_Valid = (state==DONE).
- Acceptance: at a rising edge with state IDLE and In_Valid=1, latch Control/In_A/In_B. In_Valid in SHIFT/DONE is ignored; there is no overlap and no queueing.
- Non-SRL ops, evaluated at the acceptance edge:
  - Result gets A&B, A|B, A+B or A-B.
  - Arithmetic is modulo 2^WIDTH; carry/borrow is discarded.
  - Next state is DONE, so Out_Valid is high in the cycle after acceptance.
- Illegal Control: Result=0, Zero=1, Illegal=1; next state DONE, with the same latency as a non-SRL op.
- SRL at acceptance: accumulator=In_A, count=In_B[SHAMT_W-1:0]; upper bits of In_B are ignored.
  - count==0: Result=In_A, next state DONE.
  - Otherwise next state SHIFT.
- SHIFT: each edge, accumulator >>= 1 (logical, zero fill) and count -= 1. On the edge where count==1, the final shift is applied and the state moves to DONE.
  - Out_Valid therefore rises n edges after the acceptance-edge result point for shamt n; total n+1 cycles from acceptance to Out_Valid.
- Zero and Illegal are registered together with Result and are valid only while Out_Valid=1.
- DONE: Result/Zero/Illegal are held stable while Out_Ready=0.
  - On an edge with Out_Ready=1: go to IDLE, Out_Valid=0. Result holds its last value; Illegal clears to 0.
  - The earliest next acceptance is the edge after return to IDLE, i.e. back-to-back issue rate is one op per 2 cycles minimum.
- In_Valid and Out_Ready both high in DONE: only the output handshake completes; the request waits in IDLE.
- Inputs are not sampled outside the acceptance edge; operand changes mid-SHIFT have no effect.

Test Plan:
- ADD: Control=0010, A=5, B=7, Out_Ready=1 -> In_Ready drops after acceptance; next cycle Out_Valid=1, Result=12, Zero=0, Illegal=0; In_Ready=1 one cycle later.
- SUB zero/wrap: A=9, B=9 -> Result=0, Zero=1. Then A=0, B=1 -> Result=0xFFFFFFFF, Zero=0.
- SRL multi-cycle: A=0x80000000, B=4 -> Out_Valid exactly 5 cycles after acceptance, Result=0x08000000.
  - B=0x20 (shamt 0) -> 1-cycle latency, Result=A.
  - B=31 -> Result=0x00000001 after 32 cycles.
- Backpressure: AND A=0xF0F0, B=0x0FF0 with Out_Ready=0 for 6 cycles -> Out_Valid and Result=0x00F0 stable throughout, In_Ready=0, a new In_Valid is ignored; Out_Ready=1 -> IDLE next edge.
- Illegal: Control=0011 -> Out_Valid next cycle with Illegal=1, Result=0, Zero=1.
  - Following OR A=1, B=2 -> Result=3, Illegal=0.
- Reset mid-op: start SRL A=0xFFFFFFFF, B=20; assert Reset_n low after 3 shift cycles (asynchronously, between edges) -> outputs clear immediately, Out_Valid never rises.
  - After release, In_Ready=1 and ADD 1+1 returns 2.

Source files
------------

// File: rtl/alu_exec_unit_if.sv
// Request/response bus of the ALU execute unit.
// The requester drives operands and the control code with In_Valid,
// and accepts the result with Out_Ready.
interface alu_exec_unit_if #(
   parameter int WIDTH = 32
);
   logic             In_Valid;
   logic             In_Ready;
   logic [3:0]       Control;
   logic [WIDTH-1:0] In_A;
   logic [WIDTH-1:0] In_B;
   logic             Out_Valid;
   logic             Out_Ready;
   logic [WIDTH-1:0] Result;
   logic             Zero;
   logic             Illegal;

   modport master (
      output In_Valid, Control, In_A, In_B, Out_Ready,
      input  In_Ready, Out_Valid, Result, Zero, Illegal
   );

   modport slave (
      input  In_Valid, Control, In_A, In_B, Out_Ready,
      output In_Ready, Out_Valid, Result, Zero, Illegal
   );
endinterface

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute unit.
// AND/OR/ADD/SUB and illegal codes finish at the acceptance edge.
// SRL shifts one bit per clock until the latched shift amount is used up.
module alu_exec_unit #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input logic              Clock,
   input logic              Reset_n,
   alu_exec_unit_if.slave   bus
);

   localparam logic [3:0] CTL_AND = 4'b0000;
   localparam logic [3:0] CTL_OR  = 4'b0001;
   localparam logic [3:0] CTL_ADD = 4'b0010;
   localparam logic [3:0] CTL_SUB = 4'b0110;
   localparam logic [3:0] CTL_SRL = 4'b1110;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               zero_q, zero_d;
   logic               illegal_q, illegal_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [SHAMT_W-1:0] count_q, count_d;

   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH-1:0]   accShift;
   logic [WIDTH-1:0]   opResult;
   logic               opIllegal;
   logic               opIsSrl;
   logic               srlNeedsShift;

   // Decode the incoming control code into a single-cycle result,
   // the illegal flag and whether a multi-cycle shift is needed.
   always_comb begin
      opResult  = '0;
      opIllegal = 1'b0;
      opIsSrl   = 1'b0;
      shamt     = bus.In_B[SHAMT_W-1:0];
      unique case (bus.Control)
         CTL_AND: opResult = bus.In_A & bus.In_B;
         CTL_OR:  opResult = bus.In_A | bus.In_B;
         CTL_ADD: opResult = bus.In_A + bus.In_B;
         CTL_SUB: opResult = bus.In_A - bus.In_B;
         CTL_SRL: begin
            opIsSrl  = 1'b1;
            opResult = bus.In_A;
         end
         default: opIllegal = 1'b1;
      endcase
      srlNeedsShift = opIsSrl && (shamt != '0);
      accShift      = acc_q >> 1;
   end

   // State register; reset aborts any operation in flight.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: accept only in IDLE, shift until the count runs out,
   // hold in DONE until the consumer takes the result.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.In_Valid) begin
               state_d = srlNeedsShift ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            if (count_q == SHAMT_W'(1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.Out_Ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic; In_Ready is also held low while reset is asserted.
   always_comb begin
      bus.In_Ready  = (state_q == IDLE) && Reset_n;
      bus.Out_Valid = (state_q == DONE);
      bus.Result    = result_q;
      bus.Zero      = zero_q;
      bus.Illegal   = illegal_q;
   end

   // Datapath next values: capture at acceptance, shift in SHIFT,
   // drop the illegal flag once the result has been consumed.
   always_comb begin
      result_d  = result_q;
      zero_d    = zero_q;
      illegal_d = illegal_q;
      acc_d     = acc_q;
      count_d   = count_q;
      case (state_q)
         IDLE: begin
            if (bus.In_Valid) begin
               illegal_d = opIllegal;
               acc_d     = bus.In_A;
               count_d   = shamt;
               if (!srlNeedsShift) begin
                  result_d = opResult;
                  zero_d   = (opResult == '0);
               end
            end
         end
         SHIFT: begin
            acc_d   = accShift;
            count_d = count_q - SHAMT_W'(1);
            if (count_q == SHAMT_W'(1)) begin
               result_d = accShift;
               zero_d   = (accShift == '0);
            end
         end
         DONE: begin
            if (bus.Out_Ready) begin
               illegal_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers: result, flags, shift accumulator and counter.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         result_q  <= '0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
         acc_q     <= '0;
         count_q   <= '0;
      end else begin
         result_q  <= result_d;
         zero_q    <= zero_d;
         illegal_q <= illegal_d;
         acc_q     <= acc_d;
         count_q   <= count_d;
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases followed by random
// operations, all compared against an arithmetic reference model.
module tb_alu_exec_unit;

   logic clock;
   logic reset_n;
   int   vectors;
   int   checks;
   int   miscompares;

   alu_exec_unit_if #(.WIDTH(32)) bus ();

   alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
      .Clock   (clock),
      .Reset_n (reset_n),
      .bus     (bus)
   );

   // Free-running 10 ns clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Reference result computed straight from the operation definitions.
   function automatic logic [31:0] modelResult(input logic [3:0] ctl, input logic [31:0] a,
                                               input logic [31:0] b);
      case (ctl)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return a + b;
         4'b0110: return a - b;
         4'b1110: return a >> b[4:0];
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic modelIllegal(input logic [3:0] ctl);
      return !(ctl == 4'b0000 || ctl == 4'b0001 || ctl == 4'b0010 ||
               ctl == 4'b0110 || ctl == 4'b1110);
   endfunction

   // Clock edges between the first sample after acceptance and Out_Valid.
   function automatic int modelLatency(input logic [3:0] ctl, input logic [31:0] b);
      return (ctl == 4'b1110) ? int'(b[4:0]) : 0;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Issue one operation, measure its latency, optionally stall the output
   // for holdCycles while a stray request is presented, then consume it.
   task automatic applyStimulus(input logic [3:0] ctl, input logic [31:0] a,
                                input logic [31:0] b, input int holdCycles);
      logic [31:0] expResult;
      logic        expIllegal;
      int          waited;
      int          lat;
      expResult  = modelResult(ctl, a, b);
      expIllegal = modelIllegal(ctl);
      vectors++;
      @(negedge clock);
      waited = 0;
      while (!bus.In_Ready && waited < 10) begin
         @(negedge clock);
         waited++;
      end
      checkOutput("inReadyBeforeIssue", 32'(bus.In_Ready), 32'd1);
      bus.Control  = ctl;
      bus.In_A     = a;
      bus.In_B     = b;
      bus.In_Valid = 1'b1;
      @(negedge clock);
      bus.In_Valid = 1'b0;
      bus.In_A     = $urandom;
      bus.In_B     = $urandom;
      checkOutput("inReadyAfterAccept", 32'(bus.In_Ready), 32'd0);
      lat = 0;
      while (!bus.Out_Valid && lat < 40) begin
         @(negedge clock);
         lat++;
      end
      checkOutput("latency", 32'(lat), 32'(modelLatency(ctl, b)));
      checkOutput("result", bus.Result, expResult);
      checkOutput("zero", 32'(bus.Zero), 32'(expResult == 32'd0));
      checkOutput("illegal", 32'(bus.Illegal), 32'(expIllegal));
      for (int i = 0; i < holdCycles; i++) begin
         bus.In_Valid = 1'b1;
         bus.Control  = 4'($urandom_range(0, 15));
         @(negedge clock);
         checkOutput("holdValid", 32'(bus.Out_Valid), 32'd1);
         checkOutput("holdResult", bus.Result, expResult);
         checkOutput("holdInReady", 32'(bus.In_Ready), 32'd0);
      end
      bus.In_Valid  = 1'b0;
      bus.Out_Ready = 1'b1;
      @(negedge clock);
      bus.Out_Ready = 1'b0;
      checkOutput("validAfterTake", 32'(bus.Out_Valid), 32'd0);
      checkOutput("inReadyAfterTake", 32'(bus.In_Ready), 32'd1);
      checkOutput("illegalAfterTake", 32'(bus.Illegal), 32'd0);
      checkOutput("resultAfterTake", bus.Result, expResult);
   endtask

   // Directed cases, random traffic and a reset during a long shift.
   initial begin
      logic [3:0]  ctlTable [5];
      logic [3:0]  ctl;
      logic [31:0] b;
      ctlTable[0] = 4'b0000;
      ctlTable[1] = 4'b0001;
      ctlTable[2] = 4'b0010;
      ctlTable[3] = 4'b0110;
      ctlTable[4] = 4'b1110;
      vectors       = 0;
      checks        = 0;
      miscompares   = 0;
      reset_n       = 1'b0;
      bus.In_Valid  = 1'b0;
      bus.Out_Ready = 1'b0;
      bus.Control   = 4'b0000;
      bus.In_A      = 32'd0;
      bus.In_B      = 32'd0;

      #3;
      checkOutput("resetInReady", 32'(bus.In_Ready), 32'd0);
      checkOutput("resetOutValid", 32'(bus.Out_Valid), 32'd0);
      checkOutput("resetResult", bus.Result, 32'd0);
      checkOutput("resetZero", 32'(bus.Zero), 32'd0);
      checkOutput("resetIllegal", 32'(bus.Illegal), 32'd0);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      checkOutput("inReadyAfterRelease", 32'(bus.In_Ready), 32'd1);

      $display("[TB] directed operations");
      applyStimulus(4'b0010, 32'd5, 32'd7, 0);
      applyStimulus(4'b0110, 32'd9, 32'd9, 0);
      applyStimulus(4'b0110, 32'd0, 32'd1, 0);
      applyStimulus(4'b1110, 32'h8000_0000, 32'd4, 0);
      applyStimulus(4'b1110, 32'h1234_5678, 32'h20, 0);
      applyStimulus(4'b1110, 32'h8000_0000, 32'd31, 0);
      applyStimulus(4'b0000, 32'h0000_F0F0, 32'h0000_0FF0, 6);
      applyStimulus(4'b0011, 32'hDEAD_BEEF, 32'h1, 0);
      applyStimulus(4'b0001, 32'd1, 32'd2, 0);
      applyStimulus(4'b0010, 32'hFFFF_FFFF, 32'd1, 1);

      $display("[TB] random operations");
      for (int n = 0; n < 30; n++) begin
         if ($urandom_range(0, 5) == 0) begin
            ctl = 4'($urandom_range(0, 15));
         end else begin
            ctl = ctlTable[$urandom_range(0, 4)];
         end
         b = $urandom;
         if ($urandom_range(0, 3) == 0) begin
            b = 32'($urandom_range(0, 3));
         end
         applyStimulus(ctl, $urandom, b, int'($urandom_range(0, 3)));
      end

      $display("[TB] reset during shift");
      vectors++;
      @(negedge clock);
      bus.Control  = 4'b1110;
      bus.In_A     = 32'hFFFF_FFFF;
      bus.In_B     = 32'd20;
      bus.In_Valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.In_Valid = 1'b0;
      repeat (3) @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("midResetOutValid", 32'(bus.Out_Valid), 32'd0);
      checkOutput("midResetResult", bus.Result, 32'd0);
      checkOutput("midResetZero", 32'(bus.Zero), 32'd0);
      checkOutput("midResetInReady", 32'(bus.In_Ready), 32'd0);
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 25; i++) begin
         @(negedge clock);
         checkOutput("noResultAfterReset", 32'(bus.Out_Valid), 32'd0);
      end
      checkOutput("inReadyAfterMidReset", 32'(bus.In_Ready), 32'd1);
      applyStimulus(4'b0010, 32'd1, 32'd1, 0);

      $display("[TB] %0d comparisons made", checks);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
